// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
//   Free-running unsigned up-counter for the frequency meter. The same block
//   serves as the reference-clock counter and as the measured-clock counter.
//   The count wraps at a terminal value. The terminal value is 2^WIDTH-1 in
//   full-range mode (MODULUS=0), or MODULUS-1 when MODULUS>0.
//
// Parameters
//   WIDTH    counter width in bits (1..64)
//   MODULUS  0 = full range; N>0 = count 0..N-1 (N must not exceed 2^WIDTH)
//
// Ports
//   clock   in   1      sole clock; all state changes on its rising edge
//   sclr    in   1      synchronous active-high clear (q <= 0)
//   aclr    in   1      second clear request; also sampled on clock, same
//                       priority as sclr
//   cnt_en  in   1      count enable; 0 holds q
//   sload   in   1      synchronous load of data into q
//   data    in   WIDTH  load value; reduced modulo MODULUS when MODULUS>0
//   cout    out  1      terminal-count flag, decoded from q only
//   q       out  WIDTH  current count, registered
//
// Per-edge priority: clear > load > count > hold.
// -----------------------------------------------------------------------------
module counter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MODULUS = 0
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             aclr,
  input  logic             cnt_en,
  input  logic             sload,
  input  logic [WIDTH-1:0] data,
  output logic             cout,
  output logic [WIDTH-1:0] q
);

  // Terminal count. The modulo arm is computed in 64 bits so that
  // MODULUS-1 never underflows into the WIDTH-bit constant.
  localparam logic [63:0]      MOD64 = 64'(MODULUS);
  localparam logic [63:0]      TERM64 = (MODULUS == 32'd0) ? 64'd0 : (MOD64 - 64'd1);
  localparam logic [WIDTH-1:0] TERM  = (MODULUS == 32'd0) ? {WIDTH{1'b1}}
                                                          : TERM64[WIDTH-1:0];

  // Count register. The declaration value gives a defined power-up state on
  // FPGA targets before the first clear arrives.
  logic [WIDTH-1:0] r_q = '0;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_inc;
  logic             w_clr;
  logic             w_is_term;

  // Load value, reduced into the legal count range when a modulus is set.
  generate
    if (MODULUS == 32'd0) begin : g_full_range
      assign w_load_val = data;
    end else begin : g_modulo
      // Division by a constant; the reduction is done in 64 bits so that
      // WIDTH and MODULUS never need a common narrower width.
      logic [63:0] w_mod64;
      assign w_mod64    = 64'(data) % MOD64;
      assign w_load_val = w_mod64[WIDTH-1:0];
    end
  endgenerate

  assign w_clr     = sclr | aclr;
  assign w_is_term = (r_q == TERM);
  // Wrapping at TERM covers both modes. In full range the +1 overflows to 0
  // anyway. With a modulus, the explicit compare is what forces the wrap.
  assign w_inc     = w_is_term ? {WIDTH{1'b0}} : (r_q + {{(WIDTH-1){1'b0}}, 1'b1});

  // Next-count selection: clear > load > count > hold.
  always_comb begin
    w_q_nxt = r_q;
    if (w_clr) begin
      w_q_nxt = {WIDTH{1'b0}};
    end else if (sload) begin
      w_q_nxt = w_load_val;
    end else if (cnt_en) begin
      w_q_nxt = w_inc;
    end else begin
      w_q_nxt = r_q;
    end
  end

  // Count register update. The clear is synchronous and takes the highest priority.
  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_q <= {WIDTH{1'b0}};
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign q    = r_q;
  assign cout = w_is_term;

endmodule

// File: tb/tb_counter.sv
// -----------------------------------------------------------------------------
// tb_counter
//   Drives two counter instances from shared controls:
//     dut   : WIDTH=32, MODULUS=0 (full range)
//     dut5  : WIDTH=8,  MODULUS=5
//   A behavioural model computes the expected count with plain modular
//   arithmetic. A compare process checks both instances against the model on
//   every falling edge. Directed literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_counter;

  logic        clock = 1'b0;
  logic        sclr, aclr, cnt_en, sload;
  logic [31:0] data;
  logic        cout;
  logic [31:0] q;
  logic        cout5;
  logic [7:0]  q5;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  always #5 clock = ~clock;

  counter #(.WIDTH(32), .MODULUS(0)) dut (
    .clock(clock), .sclr(sclr), .aclr(aclr), .cnt_en(cnt_en), .sload(sload),
    .data(data), .cout(cout), .q(q)
  );

  counter #(.WIDTH(8), .MODULUS(5)) dut5 (
    .clock(clock), .sclr(sclr), .aclr(aclr), .cnt_en(cnt_en), .sload(sload),
    .data(data[7:0]), .cout(cout5), .q(q5)
  );

  // Behavioural model: the count is an integer reduced modulo the range size.
  longint unsigned m_q  = 0;
  longint unsigned m5_q = 0;
  localparam longint unsigned RANGE32 = 64'd1 << 32;

  always @(posedge clock) begin
    if (sclr || aclr) begin
      m_q  <= 0;
      m5_q <= 0;
    end else if (sload) begin
      m_q  <= longint'(data);
      m5_q <= (longint'(data) % 256) % 5;
    end else if (cnt_en) begin
      m_q  <= (m_q + 1) % RANGE32;
      m5_q <= (m5_q + 1) % 5;
    end
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      check("model_q",     q,     m_q);
      check("model_cout",  cout,  (m_q == RANGE32 - 1) ? 1 : 0);
      check("model_q5",    q5,    m5_q);
      check("model_cout5", cout5, (m5_q == 4) ? 1 : 0);
    end
  end

  task automatic edge1();
    @(negedge clock);
  endtask

  int exp5 [7] = '{0, 1, 2, 3, 4, 0, 1};
  int expc5[7] = '{0, 0, 0, 0, 1, 0, 0};

  initial begin
    sclr = 1'b1; aclr = 1'b0; cnt_en = 1'b1; sload = 1'b0; data = 32'd0;

    // 1: clear for two edges, then count
    edge1();
    chk_on = 1'b1;
    edge1();
    check("t1_clear_q", q, 0);
    check("t1_clear_cout", cout, 0);
    sclr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      edge1();
      check("t1_count_q", q, i);
      check("t1_count_cout", cout, 0);
    end

    // 4: count to 7, hold three edges, resume
    for (int i = 0; i < 4; i++) edge1();
    check("t4_at7", q, 7);
    cnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge1();
      check("t4_hold", q, 7);
    end
    cnt_en = 1'b1;
    edge1();
    check("t4_resume", q, 8);

    // 5: clear beats load and count, with sclr then aclr
    for (int i = 0; i < 92; i++) edge1();
    check("t5_at100_s", q, 100);
    sclr = 1'b1; sload = 1'b1; data = 32'd9;
    edge1();
    check("t5_sclr_wins", q, 0);
    sclr = 1'b0; sload = 1'b0;
    for (int i = 0; i < 100; i++) edge1();
    check("t5_at100_a", q, 100);
    aclr = 1'b1; sload = 1'b1; data = 32'd9;
    edge1();
    check("t5_aclr_wins", q, 0);
    aclr = 1'b0; sload = 1'b0;

    // load without clear; dut5 reduces 9 -> 4
    sload = 1'b1; data = 32'd9;
    edge1();
    check("load9_q", q, 9);
    check("load9_q5", q5, 4);
    check("load9_cout5", cout5, 1);
    sload = 1'b0;

    // 2: full-range wrap
    sload = 1'b1; data = 32'hFFFF_FFFE;
    edge1();
    sload = 1'b0;
    check("t2_fffe", q, 32'hFFFF_FFFE);
    check("t2_fffe_cout", cout, 0);
    check("t2_q5_reduced", q5, 4);
    edge1();
    check("t2_ffff", q, 32'hFFFF_FFFF);
    check("t2_ffff_cout", cout, 1);
    edge1();
    check("t2_wrap0", q, 0);
    check("t2_wrap0_cout", cout, 0);
    edge1();
    check("t2_one", q, 1);

    // 3: modulus-5 sequence from 0
    sclr = 1'b1;
    edge1();
    sclr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) edge1();
      check("t3_q5", q5, exp5[i]);
      check("t3_cout5", cout5, expc5[i]);
    end

    // long clear: q stays 0, then counting resumes at 1
    sclr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge1();
      check("long_clear", q, 0);
    end
    sclr = 1'b0;
    edge1();
    check("after_clear", q, 1);

    // 6: aclr pulse that contains no rising edge
    #1 aclr = 1'b1;
    #2 aclr = 1'b0;
    edge1();
    check("t6_pulse_ignored", q, 2);
    edge1();
    check("t6_next", q, 3);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
